// File: rtl/expstate_chgq_pkg.sv
// Shared constants and types for the exported-state change queue.
// The optional per-entry timestamp is controlled by EXPSTATE_CHGQ_TIMESTAMP_EN.
package expstate_chgq_pkg;

    localparam int STAMP_W   = 16;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

`ifdef EXPSTATE_CHGQ_TIMESTAMP_EN
    localparam bit STAMP_EN = 1'b1;
`else
    localparam bit STAMP_EN = 1'b0;
`endif

    // One queued change at the default width: new state value plus the
    // cycle stamp taken at the push edge (stamp unused without the macro).
    typedef struct packed {
        logic [STAMP_W-1:0]   stamp;
        logic [DEF_WIDTH-1:0] data;
    } chg_entry_t;

    // Number of bits one FIFO entry occupies for a given state width.
    function automatic int entry_width(input int width);
        return STAMP_EN ? (width + STAMP_W) : width;
    endfunction

endpackage

// File: rtl/expstate_change_queue_chgq_fifo.sv
// chgq_fifo: show-ahead synchronous FIFO with occupancy count.
// The head entry is presented combinationally from storage and forced to
// zero while empty; full/empty are decoded from the registered count.
module chgq_fifo #(
    parameter int ENT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ENT_W-1:0]         wr_data,
    output logic [ENT_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Head entry, zeroed while empty so stale storage never leaks out.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Qualify requests: a pop needs data, a push needs room or a concurrent pop.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; reset empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observable while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/expstate_change_queue.sv
// expstate_change_queue: registers an exported TIE state onto the import
// wire, queues every cycle-to-cycle change in a show-ahead FIFO drained by
// a valid/ready handshake, and flags dropped changes with a sticky overflow.
// Define EXPSTATE_CHGQ_TIMESTAMP_EN to add a 16-bit cycle stamp per entry
// and the ChgStamp output.
module expstate_change_queue
    import expstate_chgq_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               DEPTH       = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       ExpState,
    output logic [WIDTH-1:0]       ImpWire,
    output logic                   ChgValid,
    output logic [WIDTH-1:0]       ChgData,
    input  logic                   ChgReady,
    output logic [$clog2(DEPTH):0] ChgCount,
    output logic                   Overflow,
    input  logic                   OverflowClr
`ifdef EXPSTATE_CHGQ_TIMESTAMP_EN
    ,
    output logic [STAMP_W-1:0]     ChgStamp
`endif
);

    localparam int ENT_W = entry_width(WIDTH);

    logic [WIDTH-1:0] cap_q, cap_d;
    logic             overflow_q, overflow_d;
    logic             push;
    logic             pop;
    logic             accept;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;

    // Change detection, handshake qualification and overflow flag update.
    always_comb begin
        cap_d      = ExpState;
        push       = (ExpState != cap_q);
        pop        = ChgReady && !fifo_empty;
        accept     = push && (!fifo_full || pop);
        drop       = push && fifo_full && !pop;
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (OverflowClr) begin
            overflow_d = 1'b0;
        end
    end

    // Capture register and sticky overflow flag.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cap_q      <= RESET_VALUE;
            overflow_q <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef EXPSTATE_CHGQ_TIMESTAMP_EN
    logic [STAMP_W-1:0] stamp_q, stamp_d;

    // Free-running cycle counter, wraps naturally at 16 bits.
    always_comb begin
        stamp_d = stamp_q + STAMP_W'(1);
    end

    // Cycle counter register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_d;
        end
    end

    // The stored stamp is the counter value at the push edge.
    assign wr_entry = {stamp_q, ExpState};
    assign ChgData  = rd_entry[WIDTH-1:0];
    assign ChgStamp = rd_entry[ENT_W-1 -: STAMP_W];
`else
    assign wr_entry = ExpState;
    assign ChgData  = rd_entry;
`endif

    chgq_fifo #(
        .ENT_W (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (Reset),
        .push    (accept),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (ChgCount),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ImpWire  = cap_q;
    assign ChgValid = !fifo_empty;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_expstate_change_queue.sv
// Self-checking bench for expstate_change_queue: directed scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a queue-based reference model. Honors EXPSTATE_CHGQ_TIMESTAMP_EN.
module tb_expstate_change_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] ExpState = '0;
    logic [31:0] ImpWire;
    logic        ChgValid;
    logic [31:0] ChgData;
    logic        ChgReady = 1'b0;
    logic [2:0]  ChgCount;
    logic        Overflow;
    logic        OverflowClr = 1'b0;
`ifdef EXPSTATE_CHGQ_TIMESTAMP_EN
    logic [15:0] ChgStamp;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    expstate_change_queue #(
        .WIDTH       (32),
        .DEPTH       (DEPTH),
        .RESET_VALUE (32'h0)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .ExpState    (ExpState),
        .ImpWire     (ImpWire),
        .ChgValid    (ChgValid),
        .ChgData     (ChgData),
        .ChgReady    (ChgReady),
        .ChgCount    (ChgCount),
        .Overflow    (Overflow),
        .OverflowClr (OverflowClr)
`ifdef EXPSTATE_CHGQ_TIMESTAMP_EN
        ,
        .ChgStamp    (ChgStamp)
`endif
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic [15:0] s;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_cap   = '0;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_stamp = '0;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            q.delete();
            m_cap   = '0;
            m_ovf   = 1'b0;
            m_stamp = '0;
        end else begin
            bit   chg;
            bit   dropped;
            ent_t e;
            chg     = (ExpState != m_cap);
            dropped = 1'b0;
            if (ChgReady && q.size() > 0) void'(q.pop_front());
            if (chg) begin
                if (q.size() < DEPTH) begin
                    e.d = ExpState;
                    e.s = m_stamp;
                    q.push_back(e);
                end else begin
                    dropped = 1'b1;
                end
            end
            if (dropped) m_ovf = 1'b1;
            else if (OverflowClr) m_ovf = 1'b0;
            m_cap   = ExpState;
            m_stamp = m_stamp + 16'd1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (!Reset) begin
            check("m_impwire", 64'(ImpWire),  64'(m_cap));
            check("m_valid",   64'(ChgValid), 64'(q.size() > 0));
            check("m_data",    64'(ChgData),  (q.size() > 0) ? 64'(q[0].d) : 64'd0);
            check("m_count",   64'(ChgCount), 64'(q.size()));
            check("m_ovf",     64'(Overflow), 64'(m_ovf));
`ifdef EXPSTATE_CHGQ_TIMESTAMP_EN
            check("m_stamp",   64'(ChgStamp), (q.size() > 0) ? 64'(q[0].s) : 64'd0);
`endif
        end
    end

    // Apply inputs at a falling edge and advance to the next falling edge.
    task automatic cyc(input logic [31:0] es, input logic rdy, input logic clr);
        ExpState    = es;
        ChgReady    = rdy;
        OverflowClr = clr;
        @(negedge CLK);
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge CLK);
        check("rst_impwire", 64'(ImpWire),  64'd0);
        check("rst_valid",   64'(ChgValid), 64'd0);
        check("rst_count",   64'(ChgCount), 64'd0);
        check("rst_ovf",     64'(Overflow), 64'd0);
        Reset = 1'b0;
        repeat (10) cyc(32'h0, 1'b0, 1'b0);
        check("idle_valid", 64'(ChgValid), 64'd0);
        check("idle_count", 64'(ChgCount), 64'd0);

        // single change, then pop
        cyc(32'h12345678, 1'b0, 1'b0);
        check("one_impwire", 64'(ImpWire),  64'h12345678);
        check("one_valid",   64'(ChgValid), 64'd1);
        check("one_data",    64'(ChgData),  64'h12345678);
        check("one_count",   64'(ChgCount), 64'd1);
        cyc(32'h12345678, 1'b1, 1'b0);
        check("pop_valid", 64'(ChgValid), 64'd0);
        check("pop_data",  64'(ChgData),  64'd0);

        // five changes into a four-deep queue
        for (int i = 1; i <= 5; i++) cyc(32'(i), 1'b0, 1'b0);
        check("ovf_count", 64'(ChgCount), 64'd4);
        check("ovf_flag",  64'(Overflow), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order", 64'(ChgData), 64'(i));
            cyc(32'd5, 1'b1, 1'b0);
        end
        check("ovf_drained", 64'(ChgCount), 64'd0);

        // clear, refill, push+pop while full
        cyc(32'd5, 1'b0, 1'b1);
        check("clr_ovf", 64'(Overflow), 64'd0);
        for (int i = 6; i <= 9; i++) cyc(32'(i), 1'b0, 1'b0);
        cyc(32'd10, 1'b1, 1'b0);
        check("full_pp_count", 64'(ChgCount), 64'd4);
        check("full_pp_ovf",   64'(Overflow), 64'd0);
        for (int i = 7; i <= 10; i++) begin
            check("full_pp_order", 64'(ChgData), 64'(i));
            cyc(32'd10, 1'b1, 1'b0);
        end

        // clear coinciding with a drop: set wins
        for (int i = 11; i <= 14; i++) cyc(32'(i), 1'b0, 1'b0);
        cyc(32'd15, 1'b0, 1'b1);
        check("set_wins", 64'(Overflow), 64'd1);
        cyc(32'd15, 1'b0, 1'b1);
        check("clr_after", 64'(Overflow), 64'd0);

        // asynchronous reset with three entries queued
        cyc(32'd15, 1'b1, 1'b0);
        check("pre_rst_count", 64'(ChgCount), 64'd3);
        #2 Reset = 1'b1;
        #1;
        check("arst_valid", 64'(ChgValid), 64'd0);
        check("arst_count", 64'(ChgCount), 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        cyc(32'hA5, 1'b0, 1'b0);
        check("rel_count", 64'(ChgCount), 64'd1);
        check("rel_data",  64'(ChgData),  64'hA5);
`ifdef EXPSTATE_CHGQ_TIMESTAMP_EN
        check("rel_stamp", 64'(ChgStamp), 64'd0);
`endif
        cyc(32'hA5, 1'b1, 1'b0);
        check("rel_empty", 64'(ChgValid), 64'd0);

`ifdef EXPSTATE_CHGQ_TIMESTAMP_EN
        // stamp wrap: pushes at counter 0xFFFE and 0x0001
        guard = 0;
        while (m_stamp != 16'hFFFE && guard < 70000) begin
            cyc(32'hA5, 1'b0, 1'b0);
            guard++;
        end
        check("wrap_reached", 64'(guard < 70000), 64'd1);
        cyc(32'hB1, 1'b0, 1'b0);
        cyc(32'hB1, 1'b0, 1'b0);
        cyc(32'hB1, 1'b0, 1'b0);
        cyc(32'hB2, 1'b0, 1'b0);
        check("wrap_stamp0", 64'(ChgStamp), 64'hFFFE);
        check("wrap_data0",  64'(ChgData),  64'hB1);
        cyc(32'hB2, 1'b1, 1'b0);
        check("wrap_stamp1", 64'(ChgStamp), 64'h0001);
        check("wrap_data1",  64'(ChgData),  64'hB2);
        cyc(32'hB2, 1'b1, 1'b0);
`else
        guard = 0;
`endif

        // randomized traffic over a small value set so repeats are common
        for (int i = 0; i < 600; i++) begin
            cyc(32'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/expstate_change_queue.md
# expstate_change_queue

Sits directly downstream of a core's exported TIE state port (32-bit `TIE_EXPSTATE`) and directly upstream of the consuming core's imported wire (`TIE_IMPWIRE`). It registers the exported state onto the import wire, detects every cycle-to-cycle change of that state, and queues each new value in a small FIFO. A consumer that must see every update, not only the latest level, drains the FIFO through a valid/ready handshake. Sticky overflow reporting catches lost updates.

## Interface
Parameters:
- `WIDTH`, 32: exported-state width.
- `DEPTH`, 4: change-FIFO entries; power of two, ≥ 2.
- `RESET_VALUE`, 0: reset value of the capture register and of `ImpWire`.

Ports:
- `CLK`  in  1  single clock; all state on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `ExpState`  in  WIDTH  exported state from the producer core.
- `ImpWire`  out  WIDTH  registered copy of `ExpState`, to the consumer core's import wire.
- `ChgValid`  out  1  FIFO non-empty.
- `ChgData`  out  WIDTH  head entry (show-ahead); all zeros when empty.
- `ChgReady`  in  1  consumer pop request.
- `ChgCount`  out  $clog2(DEPTH)+1  current occupancy.
- `Overflow`  out  1  sticky; set when a change is dropped.
- `OverflowClr`  in  1  clears `Overflow`.
- `ChgStamp`  out  16  head-entry timestamp; only present with the macro (see Configuration).

## Operation
- Capture register `cap <= ExpState` every cycle. `ImpWire = cap`.
- Change detect: `push = (ExpState != cap)`. The pushed value is the new `ExpState`, not `cap`.
- Pop: `ChgValid && ChgReady`. `ChgReady` while empty is ignored.
- Push, not full: write at the tail and increment `ChgCount`.
- Push, full, no pop: the value is dropped, `Overflow <= 1`, FIFO unchanged.
- Push and pop in the same cycle, any occupancy including full: both take effect, count unchanged, no overflow.
- Pop only: head advances and count decrements.
- `OverflowClr` together with a new overflow in the same cycle: set wins, `Overflow` stays 1.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty are taken from `ChgCount` (== DEPTH / == 0).
- Reset values: `cap` and `ImpWire` = `RESET_VALUE`; pointers, count, `ChgValid`, `Overflow` = 0; `ChgData` = 0; `ChgStamp` = 0.
- Reset asserted mid-operation discards all queued entries immediately (asynchronously).
- On the first edge after reset release, if `ExpState != RESET_VALUE`, that value is pushed.

## Timing
- `ExpState` → `ImpWire`: 1 cycle.
- `ExpState` change → `ChgValid`/`ChgData` visible: 1 cycle (push at edge N, valid after edge N).
- Pop at edge N: the next head, or empty, is visible after edge N.
- A value held stable for k cycles produces exactly one entry. A value toggling every cycle produces one entry per cycle.
- `Overflow` rises on the edge where the drop occurs.
- All outputs are registered or decoded directly from registers. There is no combinational path from `ChgReady` or `ExpState` to any output.

## Configuration
- `EXPSTATE_CHGQ_TIMESTAMP_EN` defined:
  - A free-running 16-bit cycle counter is added. It resets to 0 and wraps 0xFFFF→0x0000.
  - Each FIFO entry also stores the counter value at the push edge. `ChgStamp` presents the head entry's stamp and is 0 when empty.
- Undefined: no counter, no stamp storage, and no `ChgStamp` port. All other behaviour is identical.

## Structure
- Shared package `expstate_chgq_pkg`: `STAMP_W = 16`, `chg_entry_t` (data plus optional stamp), and the default `WIDTH`/`DEPTH` constants.
- One sub-module, `chgq_fifo`: a parameterised show-ahead synchronous FIFO (DEPTH × entry width) with push, pop, count, full and empty.
- The top holds the capture register, change detect, overflow flag and timestamp counter.

## Test plan
- Reset with `ExpState`=0, hold 10 cycles → `ImpWire`=0, `ChgValid`=0, `ChgCount`=0, `Overflow`=0.
- `ExpState` 0→0x12345678 at cycle 5, `ChgReady`=0 → `ImpWire`=0x12345678 and `ChgValid`=1 from cycle 6, `ChgData`=0x12345678, `ChgCount`=1. Pop → empty, `ChgData`=0.
- DEPTH=4, `ChgReady`=0, `ExpState` = 1,2,3,4,5 on consecutive cycles → `ChgCount`=4, entries 1..4, `Overflow`=1, value 5 lost. Pop four times → 1,2,3,4 in order.
- Full FIFO, new change with `ChgReady`=1 in the same cycle → count stays 4, `Overflow` stays 0, new value at the tail.
- `OverflowClr` pulse while a drop occurs → `Overflow`=1. Next `OverflowClr` with no drop → 0.
- Assert `Reset` with 3 entries queued → `ChgValid`=0 and `ChgCount`=0 immediately. Release with `ExpState`=0xA5 → one entry 0xA5 one cycle later. With the macro defined: stamps are 0 after reset, and entries pushed at counter 0xFFFE and 0x0001 read back with those stamps (wrap check).
